relu_wb_sched: RTL and testbench

RELU_WB_SCHED -- requirements
Module: relu_wb_sched

---
 rtl/relu_wb_pkg.sv | 18 +
 rtl/relu_lane_cnt.sv | 38 +++
 rtl/relu_wb_sched.sv | 125 ++++++++++++
 tb/tb_relu_wb_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/relu_wb_pkg.sv
// Shared types and constants for the ReLU write-back scheduler.
// Lane-count helpers are used by relu_wb_sched with and without RELU_WB_ERR_EN.
package relu_wb_pkg;

  localparam int unsigned MAX_LANES = 4;
  localparam int unsigned LANE_W    = 2;

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  function automatic logic [2:0] clamp_lanes(input logic [2:0] n);
    return (n > 3'(MAX_LANES)) ? 3'(MAX_LANES) : n;
  endfunction

  function automatic logic lanes_legal(input logic [2:0] n);
    return (n != 3'd0) && (n <= 3'(MAX_LANES));
  endfunction

endpackage

// File: rtl/relu_lane_cnt.sv
// Lane index counter: clear, load of lane count, increment and last-lane flag.
module relu_lane_cnt
  import relu_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [2:0]        max_in,
  input  logic              inc,
  output logic [LANE_W-1:0] idx,
  output logic [2:0]        max_lanes,
  output logic              last
);

  logic [LANE_W-1:0] idx_q;
  logic [2:0]        max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      max_q <= '0;
    end else if (load) begin
      idx_q <= '0;
      max_q <= max_in;
    end else if (clear) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign idx       = idx_q;
  assign max_lanes = max_q;
  // Three-bit compare so a count of four matches index three.
  assign last      = (({1'b0, idx_q} + 3'd1) == max_q);

endmodule

// File: rtl/relu_wb_sched.sv
// ReLU write-back burst scheduler: one write per lane at base_addr + lane.
// Define RELU_WB_ERR_EN to reject illegal num_lanes with an err pulse; otherwise err is tied low.
module relu_wb_sched
  import relu_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        num_lanes,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        sel_mux_relu,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LANE_W-1:0] idx;
  logic [2:0]        lanes;
  logic              last;
  logic              start_ok;
  logic [2:0]        lanes_eff;
  logic              cnt_load, cnt_clear, cnt_inc;

`ifdef RELU_WB_ERR_EN
  logic err_q;

  assign lanes_eff = num_lanes;
  assign start_ok  = start && !abort && lanes_legal(num_lanes);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == StIdle) && start && !abort && !lanes_legal(num_lanes);
    end
  end

  assign err = err_q;
`else
  assign lanes_eff = clamp_lanes(num_lanes);
  assign start_ok  = start && !abort;
  assign err       = 1'b0;
`endif

  relu_lane_cnt u_lane_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .max_in    (lanes_eff),
    .inc       (cnt_inc),
    .idx       (idx),
    .max_lanes (lanes),
    .last      (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_load) base_q <= base_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    sel_mux_relu = '0;
    busy         = 1'b1;
    done         = 1'b0;
    cnt_load     = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start_ok) begin
          state_d  = StLoad;
          cnt_load = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (lanes == 3'd0) begin
          state_d = StDone;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_valid     = 1'b1;
        wr_addr      = base_q + ADDR_W'(idx);
        sel_mux_relu = idx;
        // Abort wins over a simultaneous acceptance.
        if (abort) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (wr_ready) begin
          cnt_inc = 1'b1;
          if (last) state_d = StDone;
        end
      end
      StDone: begin
        done      = !abort;
        state_d   = StIdle;
        cnt_clear = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_relu_wb_sched.sv
// Self-checking bench for relu_wb_sched: vector table, random bursts, corner sequences.
module tb_relu_wb_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] num_lanes = '0;
  logic [7:0] base_addr = '0;
  logic       wr_ready = 1'b0;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [1:0] sel_mux_relu;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  relu_wb_sched #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_lanes    (num_lanes),
    .base_addr    (base_addr),
    .wr_ready     (wr_ready),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .sel_mux_relu (sel_mux_relu),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one burst; expectations come from the lane/address rules, not from DUT state.
  task automatic run_burst(input logic [2:0] n, input logic [7:0] b, input int stall0,
                           input bit rnd, output int nw, output logic [7:0] last_a);
    int   exp_n;
    bit   exp_err;
    int   first_v, last_acc, done_cyc, done_cnt, err_cnt;
    int   hold_bad, idle_bad, addr_bad;
    bit   pend, finished;
    logic [7:0] pa, ea;
    logic [1:0] ps;

    exp_err = 1'b0;
    exp_n   = int'(n);
`ifdef RELU_WB_ERR_EN
    if (n == 3'd0 || n > 3'd4) begin
      exp_err = 1'b1;
      exp_n   = 0;
    end
`else
    if (n > 3'd4) exp_n = 4;
`endif
    nw = 0; last_a = '0; first_v = -1; last_acc = -1; done_cyc = -1; done_cnt = 0;
    err_cnt = 0; hold_bad = 0; idle_bad = 0; addr_bad = 0; pend = 0; finished = 0;
    pa = '0; ps = '0;

    @(negedge clk);
    start = 1'b1; abort = 1'b0; num_lanes = n; base_addr = b; wr_ready = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start     = 1'b0;
      num_lanes = 3'($urandom);
      base_addr = 8'($urandom);
      if (nw == 0 && c < 2 + stall0) wr_ready = 1'b0;
      else wr_ready = rnd ? 1'($urandom) : 1'b1;
      #1;
      if (c == 1) chk("err_pulse_timing", {31'd0, err}, {31'd0, exp_err});
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (wr_valid) begin
        if (first_v < 0) first_v = c;
        if (pend && (wr_addr != pa || sel_mux_relu != ps)) hold_bad++;
        ea = b + 8'(nw);
        if (wr_ready) begin
          chk("wr_addr", {24'd0, wr_addr}, {24'd0, ea});
          chk("sel_mux_relu", {30'd0, sel_mux_relu}, {30'd0, 2'(nw)});
          last_a   = wr_addr;
          last_acc = c;
          nw++;
          pend = 1'b0;
        end else begin
          if (wr_addr != ea || sel_mux_relu != 2'(nw)) addr_bad++;
          pend = 1'b1;
          pa   = wr_addr;
          ps   = sel_mux_relu;
        end
      end else if (wr_addr != 8'd0 || sel_mux_relu != 2'd0) begin
        idle_bad++;
      end
      if (c >= 2 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    wr_ready = 1'b0;
    chk("burst_terminated", {31'd0, finished}, 32'd1);
    chk("write_count", nw, exp_n);
    chk("done_count", done_cnt, exp_err ? 0 : 1);
    chk("err_count", err_cnt, exp_err ? 1 : 0);
    chk("hold_stable", hold_bad, 0);
    chk("stalled_addr", addr_bad, 0);
    chk("idle_outputs_zero", idle_bad, 0);
    if (!exp_err && exp_n > 0) begin
      chk("first_valid_latency", first_v, 2);
      chk("done_after_last", done_cyc, last_acc + 1);
    end
    if (!exp_err && exp_n == 0) chk("empty_burst_done", done_cyc, 2);
  endtask

  typedef struct {
    logic [2:0] n;
    logic [7:0] base;
    int         stall;
    int         exp_nw;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[7];
  int   nw;
  logic [7:0] la;

  initial begin
    vecs[0] = '{3'd4, 8'h10, 0, 4, 8'h13};
    vecs[1] = '{3'd2, 8'h40, 3, 2, 8'h41};
    vecs[2] = '{3'd3, 8'hFE, 0, 3, 8'h00};
    vecs[3] = '{3'd1, 8'h7F, 1, 1, 8'h7F};
`ifdef RELU_WB_ERR_EN
    vecs[4] = '{3'd0, 8'h20, 0, 0, 8'h00};
    vecs[5] = '{3'd5, 8'h20, 0, 0, 8'h00};
    vecs[6] = '{3'd7, 8'hFF, 0, 0, 8'h00};
`else
    vecs[4] = '{3'd0, 8'h20, 0, 0, 8'h00};
    vecs[5] = '{3'd5, 8'h20, 0, 4, 8'h23};
    vecs[6] = '{3'd7, 8'hFF, 0, 4, 8'h02};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {19'd0, wr_valid, wr_addr, sel_mux_relu, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_burst(vecs[i].n, vecs[i].base, vecs[i].stall, 1'b0, nw, la);
      chk("vec_writes", nw, vecs[i].exp_nw);
      if (vecs[i].exp_nw > 0) chk("vec_last_addr", {24'd0, la}, {24'd0, vecs[i].exp_last});
    end

    // Random bursts with random back-pressure
    for (int k = 0; k < 20; k++) begin
      run_burst(3'($urandom_range(4, 1)), 8'($urandom), int'($urandom_range(3, 0)), 1'b1,
                nw, la);
    end

    // Abort on the cycle lane 1 is accepted
    @(negedge clk);
    start = 1'b1; num_lanes = 3'd4; base_addr = 8'h30; wr_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1; #1;
    chk("abort_lane1_addr", {24'd0, wr_addr}, 32'h31);
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_to_idle", {29'd0, busy, wr_valid, done}, 32'd0);
    @(negedge clk); #1;
    chk("abort_no_done", {30'd0, busy, done}, 32'd0);
    wr_ready = 1'b0;

    // Abort in LOAD
    @(negedge clk);
    start = 1'b1; num_lanes = 3'd2; base_addr = 8'h00;
    @(negedge clk); start = 1'b0; abort = 1'b1; #1;
    chk("load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); abort = 1'b0; #1;
    chk("load_abort_idle", {30'd0, busy, wr_valid}, 32'd0);

    // Start together with abort in IDLE is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_lanes = 3'd2;
    @(negedge clk); start = 1'b0; abort = 1'b0; #1;
    chk("start_abort_idle", {31'd0, busy}, 32'd0);

    // Start during DONE is ignored
    @(negedge clk);
    start = 1'b1; num_lanes = 3'd1; base_addr = 8'h09; wr_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; num_lanes = 3'd2; #1;
    chk("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk); start = 1'b0; #1;
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    chk("still_idle", {30'd0, busy, wr_valid}, 32'd0);
    wr_ready = 1'b0;

    // Reset mid-WRITE, then a normal burst
    @(negedge clk);
    start = 1'b1; num_lanes = 3'd4; base_addr = 8'h80;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    chk("pre_reset_valid", {31'd0, wr_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("async_reset_outputs", {19'd0, wr_valid, wr_addr, sel_mux_relu, busy, done, err},
        32'd0);
    @(negedge clk); rst = 1'b0;
    run_burst(3'd2, 8'h55, 0, 1'b0, nw, la);
    chk("post_reset_writes", nw, 2);
    chk("post_reset_last", {24'd0, la}, 32'h56);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
